// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter multiplexing cache-line requests onto a burst physical-memory port
module pmem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic                       pmem_mem_read,
    output logic                       pmem_mem_write,
    output logic [ADDR_W-1:0]          pmem_mem_addr,
    output logic [BEAT_W-1:0]          pmem_mem_wdata,
    input  logic [BEAT_W-1:0]          pmem_mem_rdata,
    input  logic                       pmem_mem_resp
);

    localparam int NBEAT  = LINE_W / BEAT_W;
    localparam int PTR_W  = $clog2(NUM_CH);
    localparam int BCNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, gnt, cand, lat_ch;
    logic                found;
    logic [NUM_CH-1:0]   req;
    logic [BCNT_W-1:0]   beat;
    logic [ADDR_W-1:0]   lat_addr, sel_addr;
    logic [LINE_W-1:0]   lat_line, sel_line;
    logic                sel_write;
    logic                beat_ack, last_beat;

    assign req       = ch_read | ch_write;
    assign beat_ack  = pmem_mem_resp && (state == READ || state == WRITE);
    assign last_beat = (beat == BCNT_W'(NBEAT - 1));

    // Walk the channels starting at rr_ptr; the first requester wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
            cand = (cand == PTR_W'(NUM_CH - 1)) ? '0 : cand + PTR_W'(1);
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_line  = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == PTR_W'(i)) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_line  = ch_wdata[i*LINE_W +: LINE_W];
                sel_write = ch_write[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (found) state_nxt = sel_write ? WRITE : READ;
            READ, WRITE: if (beat_ack && last_beat) state_nxt = DONE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            lat_ch   <= '0;
            lat_addr <= '0;
            lat_line <= '0;
            beat     <= '0;
            ch_rdata <= '0;
        end else begin
            if (state == IDLE && found) begin
                lat_ch   <= gnt;
                lat_addr <= sel_addr;
                lat_line <= sel_line;
                rr_ptr   <= (gnt == PTR_W'(NUM_CH - 1)) ? '0 : gnt + PTR_W'(1);
            end
            if (beat_ack) begin
                beat <= last_beat ? '0 : beat + BCNT_W'(1);
                if (state == READ) begin
                    for (int k = 0; k < NBEAT; k++) begin
                        if (beat == BCNT_W'(k)) ch_rdata[k*BEAT_W +: BEAT_W] <= pmem_mem_rdata;
                    end
                end
            end
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        pmem_mem_read  = (state == READ);
        pmem_mem_write = (state == WRITE);
        pmem_mem_addr  = (state == IDLE) ? '0 : (lat_addr & ~OFF_MASK);
        pmem_mem_wdata = '0;
        if (state == WRITE) begin
            for (int k = 0; k < NBEAT; k++) begin
                if (beat == BCNT_W'(k)) pmem_mem_wdata = lat_line[k*BEAT_W +: BEAT_W];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            ch_resp[i] = (state == DONE) && (lat_ch == PTR_W'(i));
        end
    end

endmodule
